// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences the multi-cycle mul/div unit in execute.
// It issues the start pulse, stalls PC/FD/DX, bubbles XM and then presents the write.
//
// Ports:
//   clock, reset (async, active-low)
//   dx_is_mult, dx_is_div, dx_rd, dx_opB_zero : DX latch decode
//   md_ready, md_exception, md_result          : multdiv unit status
//   ctrl_MULT, ctrl_DIV                        : one-cycle start pulses
//   stall, xm_bubble, md_busy                  : pipeline control
//   md_wb_valid, md_wb_rd, md_wb_data          : one-cycle write into XM
//
// Optional feature: define MULTDIV_DIV0_FAST_EN to skip the unit for
// divide-by-zero and write r30 <- 5 directly.
module multdiv_ctrl #(
    parameter int MAX_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dx_is_mult,
    input  logic        dx_is_div,
    input  logic [4:0]  dx_rd,
    input  logic        dx_opB_zero,
    input  logic        md_ready,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        xm_bubble,
    output logic        md_busy,
    output logic        md_wb_valid,
    output logic [4:0]  md_wb_rd,
    output logic [31:0] md_wb_data
);

    localparam int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MAX_CYCLES - 1);

    localparam logic [4:0]  EXC_RD    = 5'd30;
    localparam logic [31:0] EXC_MULT  = 32'd4;
    localparam logic [31:0] EXC_DIV   = 32'd5;
    localparam logic [31:0] EXC_TMOUT = 32'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          op_div_q, op_div_d;
    logic [4:0]    rd_q, rd_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;

    // Gated by reset so that asserting reset silences the pulse path
    // even while a mul/div still sits in DX.
    logic start;
    assign start = (dx_is_mult | dx_is_div) & reset;

`ifdef MULTDIV_DIV0_FAST_EN
    logic div0_fast;
    assign div0_fast = dx_is_div & ~dx_is_mult & dx_opB_zero;
`else
    logic unused_opb;
    assign unused_opb = dx_opB_zero;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            rd_q      <= '0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_div_q  <= op_div_d;
            rd_q      <= rd_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_div_d    = op_div_q;
        rd_d        = rd_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        ctrl_MULT   = 1'b0;
        ctrl_DIV    = 1'b0;
        stall       = 1'b0;
        md_busy     = 1'b0;
        md_wb_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stall     = 1'b1;
                    ctrl_MULT = dx_is_mult;
                    ctrl_DIV  = dx_is_div & ~dx_is_mult;
                    op_div_d  = ~dx_is_mult;
                    rd_d      = dx_rd;
                    cnt_d     = '0;
                    state_d   = BUSY;
`ifdef MULTDIV_DIV0_FAST_EN
                    if (div0_fast) begin
                        ctrl_DIV  = 1'b0;
                        wb_rd_d   = EXC_RD;
                        wb_data_d = EXC_DIV;
                        state_d   = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                stall   = 1'b1;
                md_busy = 1'b1;
                cnt_d   = cnt_q + CW'(1);
                // A ready in the last allowed cycle still wins over timeout.
                if (md_ready) begin
                    state_d = DONE;
                    if (md_exception) begin
                        wb_rd_d   = EXC_RD;
                        wb_data_d = op_div_q ? EXC_DIV : EXC_MULT;
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = md_result;
                    end
                end else if (cnt_q == LAST) begin
                    state_d   = DONE;
                    wb_rd_d   = EXC_RD;
                    wb_data_d = EXC_TMOUT;
                end
            end
            DONE: begin
                md_busy     = 1'b1;
                md_wb_valid = 1'b1;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign xm_bubble  = stall;
    assign md_wb_rd   = md_wb_valid ? wb_rd_q : 5'd0;
    assign md_wb_data = md_wb_valid ? wb_data_q : 32'd0;

endmodule
